spongent_arbiter: RTL and testbench

SPONGENT_ARBITER -- requirements
Module: spongent_arbiter

---
 rtl/spongent_arbiter.sv | 176 +++++++++++++++++
 tb/tb_spongent_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spongent_arbiter.sv
// Two-requester front end for a SPONGENT hash core: locks a grant for a whole
// message, feeds one word per core handshake, and guards every core wait with a watchdog.
module spongent_arbiter #(
  parameter int N       = 256,
  parameter int r       = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  input  logic [r-1:0] req0_data,
  input  logic [r-1:0] req1_data,
  input  logic         req0_last,
  input  logic         req1_last,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic [N-1:0] digest_out,
  output logic         digest_valid,
  output logic         digest_id,
  output logic         error,
  output logic         core_rst,
  output logic [r-1:0] core_data_input,
  output logic         core_data_ready,
  output logic         core_start_hash,
  input  logic         core_busy,
  input  logic         core_end_hash,
  input  logic [N-1:0] core_digest
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_PULSE, S_WAIT_HI, S_WAIT_LO, S_FINAL, S_CORE_RST
  } state_e;

  state_e         state_q, state_d;
  logic           prio_q, prio_d;
  logic           grant_q, grant_d;
  logic [r-1:0]   word_q, word_d;
  logic           last_q, last_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [N-1:0]   dig_q, dig_d;
  logic           dvalid_q, dvalid_d;
  logic           err_q, err_d;
  logic           did_q, did_d;
  logic           crst_q, crst_d;
  logic           cdr_q, cdr_d;
  logic           csh_q, csh_d;
  logic           hold_q;

  logic           sel_valid;
  logic [r-1:0]   sel_data;
  logic           sel_last;
  logic           timeout;
  logic           abort;

  assign sel_valid = grant_q ? req1_valid : req0_valid;
  assign sel_data  = grant_q ? req1_data  : req0_data;
  assign sel_last  = grant_q ? req1_last  : req0_last;
  assign timeout   = (wd_q == WDW'(TIMEOUT - 1));

  assign req0_ready = (state_q == S_FETCH) && !grant_q && req0_valid;
  assign req1_ready = (state_q == S_FETCH) &&  grant_q && req1_valid;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    word_d  = word_q;
    last_d  = last_q;
    dig_d   = dig_q;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d = (req0_valid && req1_valid) ? prio_q : !req0_valid;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (sel_valid) begin
          word_d  = sel_data;
          last_d  = sel_last;
          state_d = S_PULSE;
        end
      end
      S_PULSE:   state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (core_busy)    state_d = S_WAIT_LO;
        else if (timeout) abort   = 1'b1;
      end
      S_WAIT_LO: begin
        if (!core_busy)   state_d = last_q ? S_FINAL : S_FETCH;
        else if (timeout) abort   = 1'b1;
      end
      S_FINAL: begin
        if (core_end_hash && !core_busy) begin
          dig_d   = core_digest;
          state_d = S_CORE_RST;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      S_CORE_RST: begin
        prio_d  = !grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_CORE_RST;
  end

  // Watchdog restarts on every state change so each wait state gets a full budget.
  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q)
      wd_d = '0;
    else if (state_q inside {S_WAIT_HI, S_WAIT_LO, S_FINAL})
      wd_d = wd_q + 1'b1;
  end

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    cdr_d    = (state_d == S_PULSE);
    csh_d    = (state_d == S_FINAL);
    crst_d   = (state_d == S_CORE_RST) || hold_q;
    dvalid_d = (state_d == S_CORE_RST) && !abort;
    err_d    = abort;
    did_d    = (state_d == S_CORE_RST) ? grant_q : did_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prio_q   <= 1'b0;
      grant_q  <= 1'b0;
      word_q   <= '0;
      last_q   <= 1'b0;
      wd_q     <= '0;
      dig_q    <= '0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
      did_q    <= 1'b0;
      crst_q   <= 1'b1;
      cdr_q    <= 1'b0;
      csh_q    <= 1'b0;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      grant_q  <= grant_d;
      word_q   <= word_d;
      last_q   <= last_d;
      wd_q     <= wd_d;
      dig_q    <= dig_d;
      dvalid_q <= dvalid_d;
      err_q    <= err_d;
      did_q    <= did_d;
      crst_q   <= crst_d;
      cdr_q    <= cdr_d;
      csh_q    <= csh_d;
      hold_q   <= 1'b0;
    end
  end

  assign digest_out      = dig_q;
  assign digest_valid    = dvalid_q;
  assign digest_id       = did_q;
  assign error           = err_q;
  assign core_rst        = crst_q;
  assign core_data_input = word_q;
  assign core_data_ready = cdr_q;
  assign core_start_hash = csh_q;

endmodule

// File: tb/tb_spongent_arbiter.sv
// Randomized scoreboard bench for spongent_arbiter with a behavioural hash-core model.
module tb_spongent_arbiter;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         r0v, r1v, r0l, r1l;
  logic [15:0]  r0d, r1d;
  logic         req0_ready, req1_ready;
  logic [255:0] digest_out;
  logic         digest_valid, digest_id, error;
  logic         core_rst, core_data_ready, core_start_hash;
  logic [15:0]  core_data_input;
  logic         c_busy, c_end;
  logic [255:0] c_dig;

  bit stuck, longhash;
  int total, bad;

  typedef struct {
    bit           id;
    bit           err;
    logic [255:0] dig;
    int           nw;
  } exp_t;
  exp_t sb[$];

  logic [15:0] mw [0:63][0:7];
  int          ml [0:63];
  int          nmsg;
  bit          prio_m;

  spongent_arbiter #(.N(256), .r(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req1_valid(r1v),
    .req0_data(r0d), .req1_data(r1d),
    .req0_last(r0l), .req1_last(r1l),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .digest_out(digest_out), .digest_valid(digest_valid),
    .digest_id(digest_id), .error(error),
    .core_rst(core_rst), .core_data_input(core_data_input),
    .core_data_ready(core_data_ready), .core_start_hash(core_start_hash),
    .core_busy(c_busy), .core_end_hash(c_end), .core_digest(c_dig)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mix(input logic [255:0] h, input logic [15:0] w);
    return {h[250:0], h[255:251]} ^ {240'd0, w} ^ 256'h5a5a;
  endfunction

  function automatic logic [255:0] ref_digest(input int idx);
    logic [255:0] h = 256'h1;
    for (int i = 0; i < ml[idx]; i++) h = mix(h, mw[idx][i]);
    return h;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Hash core: absorbs a word per data_ready, then busy for a few cycles;
  // on start_hash it computes and raises end_hash until core_rst.
  initial begin
    int  bcnt, hcnt;
    bit  hashing;
    logic [255:0] acc;
    c_busy = 0; c_end = 0; c_dig = '0; acc = 256'h1; bcnt = 0; hcnt = 0; hashing = 0;
    forever begin
      @(posedge clk); #1;
      if (core_rst) begin
        c_busy = 0; c_end = 0; acc = 256'h1; bcnt = 0; hcnt = 0; hashing = 0;
      end else if (core_data_ready) begin
        acc    = mix(acc, core_data_input);
        c_busy = 1;
        bcnt   = stuck ? 0 : $urandom_range(2, 6);
      end else if (c_busy && !hashing && bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) c_busy = 0;
      end else if (hashing) begin
        hcnt--;
        if (hcnt == 0) begin
          hashing = 0; c_busy = 0; c_end = 1; c_dig = acc;
        end
      end else if (core_start_hash && !c_end && !c_busy) begin
        hashing = 1; c_busy = 1;
        hcnt = longhash ? 12 : $urandom_range(1, 6);
      end
    end
  end

  // Monitor: pops the scoreboard on every digest/error strobe.
  initial begin
    int dr_cnt, cyc, dr_cyc;
    logic [255:0] last_good;
    exp_t e;
    dr_cnt = 0; cyc = 0; dr_cyc = 0; last_good = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        dr_cnt = 0; last_good = '0;
        continue;
      end
      if (core_data_ready) begin
        dr_cnt++;
        dr_cyc = cyc;
      end
      if (req0_ready || req1_ready) begin
        if (sb.size() == 0)
          chk(0, "ready_unexpected", {req1_ready, req0_ready}, 0);
        else
          chk({req1_ready, req0_ready} == (sb[0].id ? 2'b10 : 2'b01), "ready_owner",
              {req1_ready, req0_ready}, sb[0].id ? 2'b10 : 2'b01);
      end
      if (digest_valid || error) begin
        chk(!(digest_valid && error), "strobe_exclusive", {digest_valid, error}, 0);
        if (sb.size() == 0) begin
          chk(0, "spurious_strobe", {digest_valid, error}, 0);
        end else begin
          e = sb.pop_front();
          chk(error == e.err, "strobe_kind", error, e.err);
          chk(digest_id == e.id, "digest_id", digest_id, e.id);
          chk(core_rst == 1'b1, "core_rst_pulse", core_rst, 1);
          chk(dr_cnt == e.nw, "data_ready_pulses", dr_cnt, e.nw);
          if (e.err) begin
            chk(digest_out == last_good, "digest_hold", digest_out, last_good);
            chk(cyc - dr_cyc == 2 + TO, "timeout_latency", cyc - dr_cyc, 2 + TO);
          end else begin
            chk(digest_out == e.dig, "digest", digest_out, e.dig);
            last_good = e.dig;
          end
          dr_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic set_req(input int id, input logic v, input logic [15:0] d, input logic l);
    if (id == 0) begin r0v = v; r0d = d; r0l = l; end
    else         begin r1v = v; r1d = d; r1l = l; end
  endtask

  function automatic bit rdy(input int id);
    return (id == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic new_msg(input int len, output int idx);
    idx = nmsg++;
    ml[idx] = len;
    for (int i = 0; i < len; i++) mw[idx][i] = 16'($urandom);
  endtask

  task automatic push_exp(input int id, input int idx, input bit err);
    exp_t e;
    e.id = id[0]; e.err = err; e.dig = ref_digest(idx); e.nw = err ? 1 : ml[idx];
    sb.push_back(e);
  endtask

  task automatic send(input int id, input int idx, input int gapmax);
    int n;
    for (int i = 0; i < ml[idx]; i++) begin
      @(negedge clk);
      if (i > 0) repeat ($urandom_range(0, gapmax)) @(negedge clk);
      set_req(id, 1'b1, mw[idx][i], i == ml[idx] - 1);
      #1;
      n = 0;
      while (!rdy(id) && n < 300) begin
        @(negedge clk); #1; n++;
      end
      if (!rdy(id)) begin
        chk(rdy(id), "ready_timeout", rdy(id), 1);
        set_req(id, 1'b0, '0, 1'b0);
        return;
      end
      @(posedge clk); #1;
      set_req(id, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(negedge clk); n++;
    end
    chk(sb.size() == 0, "drain_timeout", sb.size(), 0);
  endtask

  task automatic release_reset();
    rst = 0;
    @(posedge clk); #1;
    chk(core_rst == 1'b1, "core_rst_hold", core_rst, 1);
    @(posedge clk); #1;
    chk(core_rst == 1'b0, "core_rst_release", core_rst, 0);
    prio_m = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1;
    sb.delete();
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  // Both requesters queue na messages; grant order follows the alternating-priority rule.
  task automatic contend(input int na);
    int a[8], b[8];
    int i0, i1;
    bit pick;
    for (int k = 0; k < na; k++) begin
      new_msg($urandom_range(1, 3), a[k]);
      new_msg($urandom_range(1, 3), b[k]);
    end
    i0 = 0; i1 = 0;
    while (i0 < na || i1 < na) begin
      pick = (i0 < na && i1 < na) ? prio_m : (i0 >= na);
      if (pick == 0) begin push_exp(0, a[i0], 0); i0++; end
      else           begin push_exp(1, b[i1], 0); i1++; end
      prio_m = !pick;
    end
    fork
      begin for (int k = 0; k < na; k++) send(0, a[k], 2); end
      begin for (int k = 0; k < na; k++) send(1, b[k], 2); end
    join
    drain(400);
  endtask

  initial begin
    int idx, id, n;
    total = 0; bad = 0; nmsg = 0; prio_m = 0; stuck = 0; longhash = 0;
    r0v = 0; r1v = 0; r0l = 0; r1l = 0; r0d = '0; r1d = '0;
    #2 rst = 1;
    repeat (3) @(negedge clk);
    chk(digest_out == '0, "rst_digest_out", digest_out, 0);
    chk({digest_valid, error, digest_id} == 3'b000, "rst_strobes", {digest_valid, error, digest_id}, 0);
    chk({core_data_ready, core_start_hash} == 2'b00, "rst_core_ctl", {core_data_ready, core_start_hash}, 0);
    chk(core_rst == 1'b1, "rst_core_rst", core_rst, 1);
    chk(core_data_input == '0, "rst_word", core_data_input, 0);
    release_reset();

    // Fixed three-word message from req0.
    idx = nmsg++;
    ml[idx] = 3; mw[idx][0] = 16'h0001; mw[idx][1] = 16'h0002; mw[idx][2] = 16'h0003;
    push_exp(0, idx, 0);
    send(0, idx, 2);
    drain(200);
    prio_m = 1;

    apply_reset();
    contend(1);
    contend(2);

    for (int k = 0; k < 6; k++) begin
      id = $urandom_range(0, 1);
      new_msg((k == 0) ? 1 : $urandom_range(1, 4), idx);
      push_exp(id, idx, 0);
      send(id, idx, 3);
      drain(300);
      prio_m = !id[0];
    end

    // Core never drops busy: watchdog abort.
    stuck = 1;
    id = $urandom_range(0, 1);
    new_msg(1, idx);
    push_exp(id, idx, 1);
    send(id, idx, 0);
    drain(200);
    stuck = 0;
    prio_m = !id[0];

    // Reset while waiting in FINAL.
    longhash = 1;
    new_msg(2, idx);
    push_exp(1, idx, 0);
    send(1, idx, 1);
    n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (!core_start_hash && n < 100);
    chk(core_start_hash == 1'b1, "final_reached", core_start_hash, 1);
    rst = 1;
    sb.delete();
    #1;
    chk({core_start_hash, core_data_ready, digest_valid, error} == 4'b0000, "async_rst_clear",
        {core_start_hash, core_data_ready, digest_valid, error}, 0);
    chk(core_rst == 1'b1, "async_rst_core_rst", core_rst, 1);
    chk(digest_out == '0, "async_rst_digest", digest_out, 0);
    @(negedge clk);
    @(negedge clk);
    longhash = 0;
    release_reset();

    contend(1);
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
